mod_74x165_serial_tx: RTL

Serial frame transmitter built around a 74x165-style 8-bit parallel-in/serial-out shift register. It accepts a byte on a ready/load handshake and shifts it out on one line: a start bit, eight data bits MSB first (74x165 QH order), an optional parity bit, then a stop bit. It is the transmit end of the team's 74x164-based serial receiver and sits between the parallel chip-level logic and the serial link.

---
 rtl/mod_74x165_serial_tx_pkg.sv | 28 ++
 rtl/mod_74x165.sv | 38 +++
 rtl/mod_74x165_serial_tx.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mod_74x165_serial_tx_pkg.sv
// Shared state encoding and frame constants for the 74x165 serial transmitter.
// The optional parity bit is enabled with MOD_74X165_SERIAL_TX_PARITY_EN.
package mod_74x165_serial_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef MOD_74X165_SERIAL_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  localparam int unsigned DATA_BITS     = 8;
  localparam logic [2:0]  LAST_DATA_BIT = 3'(DATA_BITS - 1);
`ifdef MOD_74X165_SERIAL_TX_PARITY_EN
  localparam int unsigned FRAME_BITS    = DATA_BITS + 3;
`else
  localparam int unsigned FRAME_BITS    = DATA_BITS + 2;
`endif

  // Bit timer must hold 0..div-1.
  function automatic int unsigned timer_width(input int unsigned div);
    return $clog2(div + 1);
  endfunction

endpackage

// File: rtl/mod_74x165.sv
// 8-bit parallel-in/serial-out shift register modelled on the 74x165 pinout.
// Stage H drives QH; shifting moves SER into A and each stage toward H.
module mod_74x165 (
  input  logic CLK,
  input  logic RST,
  input  logic CLK_INH,
  input  logic SH_LD_N,
  input  logic SER,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  input  logic E,
  input  logic F,
  input  logic G,
  input  logic H,
  output logic QH,
  output logic QH_N
);

  logic [7:0] stages;

  // Parallel load is taken on the clock edge so the whole design stays in one
  // synchronous domain; the real part loads asynchronously.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stages <= '1;
    end else if (!SH_LD_N) begin
      stages <= {H, G, F, E, D, C, B, A};
    end else if (!CLK_INH) begin
      stages <= {stages[6:0], SER};
    end
  end

  assign QH   = stages[7];
  assign QH_N = ~stages[7];

endmodule

// File: rtl/mod_74x165_serial_tx.sv
// Frame transmitter: start bit, 8 data bits MSB first from a 74x165, optional
// even parity (MOD_74X165_SERIAL_TX_PARITY_EN), stop bit.
module mod_74x165_serial_tx
  import mod_74x165_serial_tx_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] D,
  input  logic       LOAD,
  output logic       READY,
  output logic       BUSY,
  output logic       SO,
  output logic       DONE
);

  localparam int unsigned     TW         = timer_width(DIV);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(DIV - 1);

  state_t        state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic [2:0]    cnt, cnt_next;
  logic          so_next, busy_next, done_next;
  logic          sh_ld_n, clk_inh;
  logic          qh, qh_n_unused;
  logic          bit_end;
`ifdef MOD_74X165_SERIAL_TX_PARITY_EN
  logic          parity_bit;
`endif

  mod_74x165 u_piso (
    .CLK     (CLK),
    .RST     (RST),
    .CLK_INH (clk_inh),
    .SH_LD_N (sh_ld_n),
    .SER     (1'b1),
    .A       (D[0]),
    .B       (D[1]),
    .C       (D[2]),
    .D       (D[3]),
    .E       (D[4]),
    .F       (D[5]),
    .G       (D[6]),
    .H       (D[7]),
    .QH      (qh),
    .QH_N    (qh_n_unused)
  );

  assign bit_end = (timer == TIMER_LAST);
  assign READY   = ~BUSY;

  // SO is registered, so each bit is loaded from QH on the edge that opens it
  // and the register is shifted on that same edge to present the next bit.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_next = state;
    timer_next = timer;
    cnt_next   = cnt;
    so_next    = SO;
    busy_next  = BUSY;
    done_next  = 1'b0;
    sh_ld_n    = 1'b1;
    clk_inh    = 1'b1;
    case (state)
      ST_IDLE: begin
        so_next   = 1'b1;
        busy_next = 1'b0;
        if (LOAD && READY) begin
          state_next = ST_START;
          timer_next = '0;
          cnt_next   = '0;
          sh_ld_n    = 1'b0;
          so_next    = 1'b0;
          busy_next  = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_next = ST_DATA;
          timer_next = '0;
          so_next    = qh;
          clk_inh    = 1'b0;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          timer_next = '0;
          if (cnt == LAST_DATA_BIT) begin
            cnt_next   = '0;
`ifdef MOD_74X165_SERIAL_TX_PARITY_EN
            state_next = ST_PARITY;
            so_next    = parity_bit;
`else
            state_next = ST_STOP;
            so_next    = 1'b1;
`endif
          end else begin
            cnt_next = cnt + 1'b1;
            so_next  = qh;
            clk_inh  = 1'b0;
          end
        end else begin
          timer_next = timer + 1'b1;
        end
      end
`ifdef MOD_74X165_SERIAL_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_next = ST_STOP;
          timer_next = '0;
          so_next    = 1'b1;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          state_next = ST_IDLE;
          timer_next = '0;
          so_next    = 1'b1;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        timer_next = '0;
        so_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
      timer <= '0;
      cnt   <= '0;
      SO    <= 1'b1;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      state <= state_next;
      timer <= timer_next;
      cnt   <= cnt_next;
      SO    <= so_next;
      BUSY  <= busy_next;
      DONE  <= done_next;
    end
  end

`ifdef MOD_74X165_SERIAL_TX_PARITY_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      parity_bit <= 1'b0;
    end else if (!sh_ld_n) begin
      parity_bit <= ^D;
    end
  end
`endif

endmodule
